// File: rtl/clp_lcd_pkg.sv
// Shared opcodes, DDRAM geometry, FSM state type and address-counter helpers
// for the HD44780-style LCD responder.
package clp_lcd_pkg;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE0_LIMIT = 7'h27;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam logic [6:0] LINE1_LIMIT = 7'h67;

    localparam int         DDRAM_DEPTH = 80;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_CLEAR
    } state_t;

    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= LINE0_LIMIT) || ((a >= LINE1_BASE) && (a <= LINE1_LIMIT));
    endfunction

    // Line 1 addresses are packed directly after the 40 entries of line 0.
    function automatic logic [6:0] ac_to_idx(input logic [6:0] a);
        if (a >= LINE1_BASE) begin
            return a - LINE1_BASE + 7'd40;
        end
        return a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE0_LIMIT) return LINE1_BASE;
            if (a == LINE1_LIMIT) return LINE0_BASE;
            return a + 7'd1;
        end
        if (a == LINE0_BASE) return LINE1_LIMIT;
        if (a == LINE1_BASE) return LINE0_LIMIT;
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/clp_e_sync.sv
// Two-flop synchronizer for the LCD bus (E, RS, RW, DB) with E level and
// E falling-edge detection in the local clock domain.
module clp_e_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e_in,
    input  logic       rs_in,
    input  logic       rw_in,
    input  logic [7:0] db_in,
    output logic       e_high,
    output logic       e_fall,
    output logic       rs,
    output logic       rw,
    output logic [7:0] db
);
    logic [10:0] meta_q, meta_d;
    logic [10:0] sync_q, sync_d;
    logic        e_prev_q, e_prev_d;

    always_comb begin
        meta_d   = {e_in, rs_in, rw_in, db_in};
        sync_d   = meta_q;
        e_prev_d = sync_q[10];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= '0;
            sync_q   <= '0;
            e_prev_q <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            e_prev_q <= e_prev_d;
        end
    end

    assign e_high = sync_q[10];
    assign e_fall = e_prev_q & ~sync_q[10];
    assign rs     = sync_q[9];
    assign rw     = sync_q[8];
    assign db     = sync_q[7:0];

endmodule

// File: rtl/clp_lcd_responder.sv
// LCD controller responder: decodes host bus cycles into a shadow DDRAM and busy model.
// Optional bus-protocol checker enabled by defining CLP_RSP_PROTOCOL_CHECK_EN.
module clp_lcd_responder #(
    parameter int CLK_PER_US = 100,
    parameter int T_CMD_US   = 37,
    parameter int T_CLR_US   = 1520
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] JB_in,
    input  logic [9:7] JC,
    output logic [7:0] JB_out,
    output logic       JB_oe,
    output logic       char_valid,
    output logic [6:0] char_addr,
    output logic [7:0] char_data,
    input  logic [6:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       disp_on,
    output logic       busy,
    output logic       proto_err
);
    import clp_lcd_pkg::*;

    localparam logic [31:0] CMD_LOAD = 32'(T_CMD_US * CLK_PER_US) - 32'd1;
    localparam logic [31:0] CLR_LOAD = 32'(T_CLR_US * CLK_PER_US) - 32'd1;

    logic       e_high, e_fall, rs_s, rw_s;
    logic [7:0] db_s;

    clp_e_sync u_sync (
        .clk    (CLK),
        .rst_n  (RSTN),
        .e_in   (JC[9]),
        .rs_in  (JC[7]),
        .rw_in  (JC[8]),
        .db_in  (JB_in),
        .e_high (e_high),
        .e_fall (e_fall),
        .rs     (rs_s),
        .rw     (rw_s),
        .db     (db_s)
    );

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [6:0]  ac_q, ac_d, fill_q, fill_d, char_addr_q, char_addr_d;
    logic        id_q, id_d, cgram_q, cgram_d, disp_q, disp_d, busy_q, busy_d;
    logic        char_valid_q, char_valid_d, jb_oe_q, jb_oe_d;
    logic [7:0]  char_data_q, char_data_d, jb_out_q, jb_out_d;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  shadow_q [DDRAM_DEPTH];

    logic cmd_wr, ins_wr, dat_wr, dat_rd;
    assign cmd_wr = e_fall & ~rw_s;
    assign ins_wr = cmd_wr & ~rs_s & (db_s != 8'h00);
    assign dat_wr = cmd_wr & rs_s;
    assign dat_rd = e_fall & rw_s & rs_s;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ac_d         = ac_q;
        fill_d       = fill_q;
        id_d         = id_q;
        cgram_d      = cgram_q;
        disp_d       = disp_q;
        char_valid_d = 1'b0;
        char_addr_d  = char_addr_q;
        char_data_d  = char_data_q;
        mem_we       = 1'b0;
        mem_addr     = fill_q;
        mem_wdata    = BLANK_CHAR;

        if ((state_q != ST_IDLE) && (timer_q != 32'd0)) begin
            timer_d = timer_q - 32'd1;
        end

        // A data write landing mid-fill takes the RAM port; the fill waits a cycle.
        case (state_q)
            ST_BUSY: if (timer_q == 32'd0) state_d = ST_IDLE;
            ST_CLEAR: begin
                if (!dat_wr) begin
                    mem_we = 1'b1;
                    if (fill_q == 7'(DDRAM_DEPTH - 1)) state_d = ST_BUSY;
                    else                               fill_d  = fill_q + 7'd1;
                end
            end
            default: ;
        endcase

        if (ins_wr || dat_wr) begin
            timer_d = CMD_LOAD;
            if (state_d != ST_CLEAR) state_d = ST_BUSY;
        end

        if (ins_wr) begin
            if (|(db_s & OP_DDRAM)) begin
                ac_d    = ac_valid(db_s[6:0]) ? db_s[6:0] : 7'h00;
                cgram_d = 1'b0;
            end else if (|(db_s & OP_CGRAM)) begin
                cgram_d = 1'b1;
            end else if (|(db_s & (OP_FUNC | OP_SHIFT))) begin
                cgram_d = cgram_q;
            end else if (|(db_s & OP_DISPLAY)) begin
                disp_d = db_s[2];
            end else if (|(db_s & OP_ENTRY)) begin
                id_d = db_s[1];
            end else if (|(db_s & OP_HOME)) begin
                ac_d    = 7'h00;
                timer_d = CLR_LOAD;
            end else if (|(db_s & OP_CLEAR)) begin
                ac_d    = 7'h00;
                id_d    = 1'b1;
                timer_d = CLR_LOAD;
                fill_d  = 7'd0;
                state_d = ST_CLEAR;
            end
        end

        if (dat_wr && !cgram_q) begin
            mem_we       = 1'b1;
            mem_addr     = ac_to_idx(ac_q);
            mem_wdata    = db_s;
            char_valid_d = 1'b1;
            char_addr_d  = ac_q;
            char_data_d  = db_s;
            ac_d         = ac_step(ac_q, id_q);
        end

        if (dat_rd) begin
            ac_d = ac_step(ac_q, id_q);
        end

        busy_d   = (state_d != ST_IDLE);
        jb_oe_d  = e_high & rw_s;
        jb_out_d = 8'h00;
        if (jb_oe_d) begin
            jb_out_d = rs_s ? shadow_q[ac_to_idx(ac_q)] : {busy_q, ac_q};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            timer_q      <= 32'd0;
            ac_q         <= 7'h00;
            fill_q       <= 7'd0;
            id_q         <= 1'b1;
            cgram_q      <= 1'b0;
            disp_q       <= 1'b0;
            busy_q       <= 1'b0;
            char_valid_q <= 1'b0;
            char_addr_q  <= 7'h00;
            char_data_q  <= 8'h00;
            jb_oe_q      <= 1'b0;
            jb_out_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ac_q         <= ac_d;
            fill_q       <= fill_d;
            id_q         <= id_d;
            cgram_q      <= cgram_d;
            disp_q       <= disp_d;
            busy_q       <= busy_d;
            char_valid_q <= char_valid_d;
            char_addr_q  <= char_addr_d;
            char_data_q  <= char_data_d;
            jb_oe_q      <= jb_oe_d;
            jb_out_q     <= jb_out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we && RSTN) begin
            shadow_q[mem_addr] <= mem_wdata;
        end
    end

    assign rd_data    = (rd_idx < 7'(DDRAM_DEPTH)) ? shadow_q[rd_idx] : 8'h00;
    assign JB_out     = jb_out_q;
    assign JB_oe      = jb_oe_q;
    assign char_valid = char_valid_q;
    assign char_addr  = char_addr_q;
    assign char_data  = char_data_q;
    assign disp_on    = disp_q;
    assign busy       = busy_q;

`ifdef CLP_RSP_PROTOCOL_CHECK_EN
    logic perr_q, perr_d, e_seen_q, e_seen_d, rw_rise_q, rw_rise_d;

    // RW is captured on the first synchronized-high cycle of E.
    always_comb begin
        e_seen_d  = e_high;
        rw_rise_d = (e_high && !e_seen_q) ? rw_s : rw_rise_q;
        perr_d    = perr_q | (cmd_wr & busy_q) | (e_fall & (rw_s != rw_rise_q));
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            perr_q    <= 1'b0;
            e_seen_q  <= 1'b0;
            rw_rise_q <= 1'b0;
        end else begin
            perr_q    <= perr_d;
            e_seen_q  <= e_seen_d;
            rw_rise_q <= rw_rise_d;
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_clp_lcd_responder.sv
// Scoreboard bench for clp_lcd_responder: random host bus traffic against a
// behavioural LCD model; char_valid events are checked by a separate monitor.
module tb_clp_lcd_responder;
    localparam int CPU = 2, TCMD = 5, TCLR = 60;
    localparam int CLR_CYC = TCLR * CPU;

    logic       CLK = 1'b0, RSTN = 1'b0;
    logic [7:0] JB_in = 8'h00;
    logic [9:7] JC = 3'b000;
    logic [6:0] rd_idx = 7'd0;
    logic [7:0] JB_out, char_data, rd_data;
    logic [6:0] char_addr;
    logic       JB_oe, char_valid, disp_on, busy, proto_err;

    always #5 CLK = ~CLK;

    clp_lcd_responder #(.CLK_PER_US(CPU), .T_CMD_US(TCMD), .T_CLR_US(TCLR)) dut (
        .CLK(CLK), .RSTN(RSTN), .JB_in(JB_in), .JC(JC), .JB_out(JB_out), .JB_oe(JB_oe),
        .char_valid(char_valid), .char_addr(char_addr), .char_data(char_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .disp_on(disp_on), .busy(busy),
        .proto_err(proto_err)
    );

    int checks = 0, errors = 0;
    typedef struct { int a; int d; } ch_t;
    ch_t exp_q[$];

    // Behavioural model state
    int m_mem[80];
    int m_ac = 0;
    bit m_id = 1'b1, m_cg = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_idx(input int a);
        return (a < 64) ? a : a - 64 + 40;
    endfunction

    function automatic int m_next(input int a);
        if (m_id) return (a == 39) ? 64 : (a == 103) ? 0 : a + 1;
        return (a == 0) ? 103 : (a == 64) ? 39 : a - 1;
    endfunction

    always @(negedge CLK) begin
        ch_t e;
        if (RSTN && char_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL char_unexpected: got addr 0x%0h data 0x%0h required no pulse",
                         char_addr, char_data);
            end else begin
                e = exp_q.pop_front();
                check("char_addr", char_addr, e.a);
                check("char_data", char_data, e.d);
                $display("char event addr 0x%0h data 0x%0h", char_addr, char_data);
            end
        end
    end

    task automatic xfer(input bit rs, input bit rw, input logic [7:0] db,
                        input int pre, input int hold, input int post);
        @(negedge CLK);
        JC = {1'b0, rw, rs};
        JB_in = db;
        repeat (pre) @(negedge CLK);
        JC[9] = 1'b1;
        repeat (hold) @(negedge CLK);
        JC[9] = 1'b0;
        repeat (post) @(negedge CLK);
    endtask

    task automatic model_ins(input logic [7:0] db);
        if (db[7]) begin
            m_ac = ((db[6:0] <= 7'h27) || (db[6:0] >= 7'h40 && db[6:0] <= 7'h67)) ? int'(db[6:0]) : 0;
            m_cg = 1'b0;
        end else if (db[6]) m_cg = 1'b1;
        else if (db[5] || db[4] || db[3]) ;
        else if (db[2]) m_id = db[1];
        else if (db[1]) m_ac = 0;
        else if (db[0]) begin
            m_ac = 0;
            m_id = 1'b1;
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        end
    endtask

    task automatic wr_ins(input logic [7:0] db);
        model_ins(db);
        xfer(1'b0, 1'b0, db, 3, 5, 4);
        $display("write instr 0x%0h", db);
    endtask

    task automatic model_dat(input logic [7:0] db);
        ch_t e;
        if (!m_cg) begin
            e.a = m_ac;
            e.d = db;
            exp_q.push_back(e);
            m_mem[m_idx(m_ac)] = db;
            m_ac = m_next(m_ac);
        end
    endtask

    task automatic wr_dat(input logic [7:0] db);
        model_dat(db);
        xfer(1'b1, 1'b0, db, 3, 5, 4);
        $display("write data 0x%0h", db);
    endtask

    task automatic rd(input bit rs, output logic [7:0] val, output logic oe);
        @(negedge CLK);
        JC = {1'b0, 1'b1, rs};
        repeat (2) @(negedge CLK);
        JC[9] = 1'b1;
        repeat (6) @(negedge CLK);
        val = JB_out;
        oe = JB_oe;
        JC[9] = 1'b0;
        repeat (4) @(negedge CLK);
        $display("read rs=%0d -> 0x%0h oe=%0d", rs, val, oe);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && busy; i++) @(negedge CLK);
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic chk_ac(input string name);
        logic [7:0] v;
        logic oe;
        rd(1'b0, v, oe);
        check({name, "_oe"}, oe, 1);
        check(name, v, m_ac);
    endtask

    initial begin
        logic [7:0] v, d;
        logic oe;
        int cnt, bad, op, b7_prev;
        bit saw1, saw0;

        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_disp_on", disp_on, 0);
        check("rst_jb_oe", JB_oe, 0);
        check("rst_jb_out", JB_out, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_proto_err", proto_err, 0);
        chk_ac("rst_ac");

        // Clear: busy length and blank fill
        model_ins(8'h01);
        xfer(1'b0, 1'b0, 8'h01, 3, 5, 0);
        for (int i = 0; i < 20 && !busy; i++) @(negedge CLK);
        cnt = 0;
        for (int i = 0; i < 5000 && busy; i++) begin
            cnt++;
            @(negedge CLK);
        end
        check("clear_busy_cycles", cnt, CLR_CYC);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            rd_idx = 7'(i);
            #1;
            if (rd_data !== 8'h20) bad++;
        end
        check("clear_fill_bad_entries", bad, 0);
        chk_ac("clear_ac");

        // Line-wrap on increment
        wr_ins(8'h80 | 8'h26); wait_idle();
        wr_dat(8'h41); wait_idle();
        wr_dat(8'h42); wait_idle();
        wr_dat(8'h43); wait_idle();
        for (int i = 38; i <= 40; i++) begin
            rd_idx = 7'(i);
            #1;
            check("wrap_shadow", rd_data, m_mem[i]);
        end

        // Decrement across the line boundary
        wr_ins(8'h04); wait_idle();
        wr_ins(8'h80 | 8'h40); wait_idle();
        wr_dat(8'h58); wait_idle();
        chk_ac("dec_ac");
        wr_ins(8'h06); wait_idle();

        // CGRAM mode drops data
        wr_ins(8'h40); wait_idle();
        wr_dat(8'h55); wait_idle();
        wr_ins(8'h80 | 8'h05); wait_idle();
        chk_ac("cgram_ac");

        // Display on, then busy/address read across the end of the busy period
        model_ins(8'h0C);
        xfer(1'b0, 1'b0, 8'h0C, 3, 5, 3);
        JC = 3'b010;
        @(negedge CLK);
        JC[9] = 1'b1;
        saw1 = 1'b0; saw0 = 1'b0; b7_prev = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i >= 3) begin
                check("busyrd_oe", JB_oe, 1);
                check("busyrd_ac", JB_out[6:0], m_ac);
                if (JB_out[7]) saw1 = 1'b1; else saw0 = 1'b1;
                if (JB_out[7] && b7_prev == 0) check("busyrd_bit7_rerise", 1, 0);
                b7_prev = JB_out[7];
            end
        end
        JC[9] = 1'b0;
        repeat (4) @(negedge CLK);
        check("busyrd_saw_busy", saw1, 1);
        check("busyrd_saw_ready", saw0, 1);
        check("disp_on", disp_on, 1);
        check("idle_jb_oe", JB_oe, 0);
        check("pre_proto_err", proto_err, 0);
        wait_idle();

        // Back-to-back writes while busy
        wr_ins(8'h80 | 8'h10); wait_idle();
        model_dat(8'h31);
        xfer(1'b1, 1'b0, 8'h31, 1, 3, 3);
        model_dat(8'h30);
        xfer(1'b1, 1'b0, 8'h30, 1, 3, 3);
        wait_idle();
        rd_idx = 7'd17;
        #1;
        check("overlap_data_stored", rd_data, 8'h30);
`ifdef CLP_RSP_PROTOCOL_CHECK_EN
        check("proto_err", proto_err, 1);
`else
        check("proto_err", proto_err, 0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            d = 8'($urandom);
            case (op)
                0: begin wr_ins(8'h80 | d); wait_idle(); end
                1: begin wr_ins(8'h04 | {6'd0, d[0], 1'b0}); wait_idle(); end
                2, 3: begin wr_dat(d); wait_idle(); end
                4: begin
                    rd(1'b1, v, oe);
                    check("rnd_rd_oe", oe, 1);
                    check("rnd_rd_data", v, m_mem[m_idx(m_ac)]);
                    m_ac = m_next(m_ac);
                end
                default: chk_ac("rnd_ac");
            endcase
        end
        chk_ac("final_ac");
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            rd_idx = 7'(i);
            #1;
            if (rd_data !== 8'(m_mem[i])) bad++;
        end
        check("final_shadow_bad_entries", bad, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        // Reset in the middle of the clear fill
        model_ins(8'h01);
        xfer(1'b0, 1'b0, 8'h01, 3, 5, 0);
        for (int i = 0; i < 20 && !busy; i++) @(negedge CLK);
        check("clr2_busy", busy, 1);
        repeat (40) @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        check("midclr_rst_busy", busy, 0);
        check("midclr_rst_proto_err", proto_err, 0);
        RSTN = 1'b1;
        m_ac = 0;
        m_id = 1'b1;
        m_cg = 1'b0;
        @(negedge CLK);
        check("midclr_busy_after", busy, 0);
        chk_ac("midclr_ac");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
